// File: rtl/msrv32_imem_fetch_if.sv
// Instruction-fetch bus bundle: PC/control from the core, request/response to
// instruction memory, and the fetched instruction toward decode.
interface msrv32_imem_fetch_if;
  logic [31:0] pc_in;
  logic        flush_in;
  logic        stall_in;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_gnt_in;
  logic        imem_rvalid_in;
  logic [31:0] imem_rdata_in;
  logic [31:0] instr_out;
  logic [31:0] instr_pc_out;
  logic        instr_valid_out;
  logic        pc_advance_out;
  logic        misaligned_out;

  // Fetch unit side
  modport master (
    input  pc_in, flush_in, stall_in, imem_gnt_in, imem_rvalid_in, imem_rdata_in,
    output imem_req_out, imem_addr_out, instr_out, instr_pc_out, instr_valid_out,
    pc_advance_out, misaligned_out
  );

  // Core / memory side
  modport slave (
    output pc_in, flush_in, stall_in, imem_gnt_in, imem_rvalid_in, imem_rdata_in,
    input  imem_req_out, imem_addr_out, instr_out, instr_pc_out, instr_valid_out,
    pc_advance_out, misaligned_out
  );
endinterface

// File: rtl/msrv32_imem_fetch.sv
// Single-outstanding instruction fetch unit. Issues one request per held
// instruction, discards responses overtaken by a flush, and pulses
// pc_advance_out so the PC register steps before the next request.
module msrv32_imem_fetch #(
  parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
  input  logic                        ms_riscv32_mp_clk_in,
  input  logic                        ms_riscv32_mp_rst_in,
  msrv32_imem_fetch_if.master         bus
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StValid} state_e;

  state_e      r_state;
  logic        r_drop;
  logic [31:0] r_pc_q;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_instr_valid;
  logic        r_pc_advance;

  logic        w_in_req;
  logic        w_aligned;
  logic        w_req;

  // Request decode: only a word-aligned PC may be presented to memory
  always_comb begin
    w_in_req  = (r_state == StReq);
    w_aligned = (bus.pc_in[1:0] == 2'b00);
    w_req     = w_in_req && w_aligned;
  end

  assign bus.imem_req_out    = w_req;
  assign bus.imem_addr_out   = bus.pc_in;
  assign bus.misaligned_out  = w_in_req && !w_aligned;
  assign bus.instr_out       = r_instr;
  assign bus.instr_pc_out    = r_instr_pc;
  assign bus.instr_valid_out = r_instr_valid;
  assign bus.pc_advance_out  = r_pc_advance;

  // Fetch FSM with registered instruction outputs and advance pulse
  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      r_state       <= StIdle;
      r_drop        <= 1'b0;
      r_pc_q        <= 32'h0;
      r_instr       <= RESET_INSTR;
      r_instr_pc    <= 32'h0;
      r_instr_valid <= 1'b0;
      r_pc_advance  <= 1'b0;
    end else begin
      r_pc_advance <= 1'b0;
      unique case (r_state)
        StIdle: r_state <= StReq;
        StReq: begin
          // Misaligned PC or ungranted request just waits here; a flush
          // simply means the redirected pc_in is used next cycle.
          if (w_req && bus.imem_gnt_in) begin
            r_pc_q  <= bus.pc_in;
            r_drop  <= bus.flush_in;
            r_state <= StWait;
          end
        end
        StWait: begin
          if (bus.imem_rvalid_in) begin
            if (r_drop || bus.flush_in) begin
              r_drop  <= 1'b0;
              r_state <= StReq;
            end else begin
              r_instr       <= bus.imem_rdata_in;
              r_instr_pc    <= r_pc_q;
              r_instr_valid <= 1'b1;
              r_pc_advance  <= 1'b1;
              r_state       <= StValid;
            end
          end else if (bus.flush_in) begin
            // Response still owed by memory; remember to throw it away
            r_drop <= 1'b1;
          end
        end
        StValid: begin
          if (bus.flush_in) begin
            r_instr_valid <= 1'b0;
            r_instr       <= RESET_INSTR;
            r_state       <= StReq;
          end else if (!bus.stall_in) begin
            r_instr_valid <= 1'b0;
            r_state       <= StReq;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_msrv32_imem_fetch.sv
// Directed bench for msrv32_imem_fetch: transaction-level model compared every
// cycle, plus literal expectations at key points of each scenario.
module tb_msrv32_imem_fetch;
  localparam logic [31:0] RESET_INSTR = 32'h0000_0013;

  logic clk;
  logic rst;
  msrv32_imem_fetch_if bus ();

  msrv32_imem_fetch #(.RESET_INSTR(RESET_INSTR)) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .bus                  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_adv  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: started, outstanding fetch, held instruction
  logic        m_started;
  logic        m_out;
  logic [31:0] m_out_pc;
  logic        m_disc;
  logic        m_held;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  logic        m_adv;

  function automatic logic may_request();
    return m_started && !m_out && !m_held;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_started <= 1'b0;
      m_out     <= 1'b0;
      m_out_pc  <= 32'h0;
      m_disc    <= 1'b0;
      m_held    <= 1'b0;
      m_instr   <= RESET_INSTR;
      m_ipc     <= 32'h0;
      m_adv     <= 1'b0;
    end else begin
      m_adv <= 1'b0;
      if (!m_started) begin
        m_started <= 1'b1;
      end else if (may_request()) begin
        if (bus.pc_in[1:0] == 2'b00 && bus.imem_gnt_in) begin
          m_out    <= 1'b1;
          m_out_pc <= bus.pc_in;
          m_disc   <= bus.flush_in;
        end
      end else if (m_out) begin
        if (bus.imem_rvalid_in) begin
          m_out  <= 1'b0;
          m_disc <= 1'b0;
          if (!(m_disc || bus.flush_in)) begin
            m_held  <= 1'b1;
            m_instr <= bus.imem_rdata_in;
            m_ipc   <= m_out_pc;
            m_adv   <= 1'b1;
          end
        end else if (bus.flush_in) begin
          m_disc <= 1'b1;
        end
      end else if (m_held) begin
        if (bus.flush_in) begin
          m_held  <= 1'b0;
          m_instr <= RESET_INSTR;
        end else if (!bus.stall_in) begin
          m_held <= 1'b0;
        end
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge
  initial begin
    logic e_req;
    forever begin
      @(negedge clk);
      e_req = may_request() && (bus.pc_in[1:0] == 2'b00);
      chk("req", {31'h0, bus.imem_req_out}, {31'h0, e_req});
      chk("misaligned", {31'h0, bus.misaligned_out},
          {31'h0, may_request() && (bus.pc_in[1:0] != 2'b00)});
      if (e_req) chk("addr", bus.imem_addr_out, bus.pc_in);
      chk("instr", bus.instr_out, m_instr);
      chk("instr_pc", bus.instr_pc_out, m_ipc);
      chk("valid", {31'h0, bus.instr_valid_out}, {31'h0, m_held});
      chk("advance", {31'h0, bus.pc_advance_out}, {31'h0, m_adv});
      if (bus.pc_advance_out) n_adv++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.pc_in = 32'h100;
    bus.flush_in = 1'b0;
    bus.stall_in = 1'b0;
    bus.imem_gnt_in = 1'b0;
    bus.imem_rvalid_in = 1'b0;
    bus.imem_rdata_in = 32'h0;
    repeat (2) tick();
    settle();
    chk("rst_instr", bus.instr_out, 32'h0000_0013);
    chk("rst_valid", {31'h0, bus.instr_valid_out}, 32'h0);
    chk("rst_req", {31'h0, bus.imem_req_out}, 32'h0);
    rst = 1'b0;
    tick();                              // IDLE -> REQ
    settle();
    chk("first_req", {31'h0, bus.imem_req_out}, 32'h1);
    chk("first_addr", bus.imem_addr_out, 32'h100);

    // Basic fetch at 0x100
    bus.imem_gnt_in = 1'b1;
    tick();
    bus.imem_gnt_in = 1'b0;
    bus.imem_rvalid_in = 1'b1;
    bus.imem_rdata_in = 32'h0050_0093;
    tick();
    settle();
    chk("fetch_instr", bus.instr_out, 32'h0050_0093);
    chk("fetch_pc", bus.instr_pc_out, 32'h100);
    chk("fetch_valid", {31'h0, bus.instr_valid_out}, 32'h1);
    chk("fetch_adv", {31'h0, bus.pc_advance_out}, 32'h1);

    // Hold under stall; PC register has stepped to 0x104
    bus.imem_rvalid_in = 1'b0;
    bus.stall_in = 1'b1;
    bus.pc_in = 32'h104;
    repeat (4) tick();
    settle();
    chk("stall_instr", bus.instr_out, 32'h0050_0093);
    chk("stall_req", {31'h0, bus.imem_req_out}, 32'h0);
    chk("stall_adv", {31'h0, bus.pc_advance_out}, 32'h0);
    bus.stall_in = 1'b0;
    tick();
    settle();
    chk("unstall_valid", {31'h0, bus.instr_valid_out}, 32'h0);
    chk("unstall_addr", {bus.imem_addr_out[31:1], bus.imem_req_out}, 32'h105);

    // Flush while waiting; late response must be discarded
    bus.imem_gnt_in = 1'b1;
    tick();
    bus.imem_gnt_in = 1'b0;
    bus.flush_in = 1'b1;
    bus.pc_in = 32'h200;
    tick();
    bus.flush_in = 1'b0;
    tick();
    bus.imem_rvalid_in = 1'b1;
    bus.imem_rdata_in = 32'hDEAD_BEEF;
    tick();
    bus.imem_rvalid_in = 1'b0;
    settle();
    chk("drop_valid", {31'h0, bus.instr_valid_out}, 32'h0);
    chk("drop_instr", bus.instr_out, 32'h0050_0093);
    chk("drop_adv", {31'h0, bus.pc_advance_out}, 32'h0);
    chk("redirect_addr", {bus.imem_addr_out[31:1], bus.imem_req_out}, 32'h201);

    // Flush coincident with the response
    bus.imem_gnt_in = 1'b1;
    tick();
    bus.imem_gnt_in = 1'b0;
    bus.imem_rvalid_in = 1'b1;
    bus.imem_rdata_in = 32'h1234_5678;
    bus.flush_in = 1'b1;
    bus.pc_in = 32'h204;
    tick();
    bus.imem_rvalid_in = 1'b0;
    bus.flush_in = 1'b0;
    settle();
    chk("coinc_valid", {31'h0, bus.instr_valid_out}, 32'h0);
    chk("coinc_req", {31'h0, bus.imem_req_out}, 32'h1);

    // Misaligned PC parks in REQ until a redirect
    bus.pc_in = 32'h102;
    settle();
    chk("mis_flag", {31'h0, bus.misaligned_out}, 32'h1);
    chk("mis_req", {31'h0, bus.imem_req_out}, 32'h0);
    bus.imem_gnt_in = 1'b1;
    repeat (2) tick();
    settle();
    chk("mis_hold", {31'h0, bus.misaligned_out}, 32'h1);
    bus.imem_gnt_in = 1'b0;
    bus.flush_in = 1'b1;
    bus.pc_in = 32'h300;
    settle();
    chk("mis_redirect", {bus.imem_addr_out[31:1], bus.imem_req_out}, 32'h301);
    tick();
    bus.flush_in = 1'b0;
    bus.imem_gnt_in = 1'b1;
    tick();
    bus.imem_gnt_in = 1'b0;
    bus.imem_rvalid_in = 1'b1;
    bus.imem_rdata_in = 32'h1111_1111;
    tick();
    bus.imem_rvalid_in = 1'b0;
    settle();
    chk("mis_fetch_pc", bus.instr_pc_out, 32'h300);

    // Flush while holding clears the instruction, even under stall
    bus.stall_in = 1'b1;
    bus.flush_in = 1'b1;
    tick();
    bus.stall_in = 1'b0;
    bus.flush_in = 1'b0;
    settle();
    chk("vflush_instr", bus.instr_out, 32'h0000_0013);
    chk("vflush_valid", {31'h0, bus.instr_valid_out}, 32'h0);

    // Reset mid-WAIT, then a stray response
    bus.pc_in = 32'h400;
    bus.imem_gnt_in = 1'b1;
    tick();
    bus.imem_gnt_in = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.imem_rvalid_in = 1'b1;
    bus.imem_rdata_in = 32'hBAD0_BAD0;
    repeat (2) tick();
    bus.imem_rvalid_in = 1'b0;
    settle();
    chk("rst2_instr", bus.instr_out, 32'h0000_0013);
    chk("rst2_pc", bus.instr_pc_out, 32'h0);
    chk("rst2_valid", {31'h0, bus.instr_valid_out}, 32'h0);
    chk("rst2_adv", {31'h0, bus.pc_advance_out}, 32'h0);
    tick();
    chk("adv_pulses", n_adv, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/msrv32_imem_fetch.md
MSRV32_IMEM_FETCH -- requirements
Module: msrv32_imem_fetch

Interface
REQ-001 Parameter RESET_INSTR, default 32'h0000_0013 (NOP), SHALL be the value instr_out holds after reset and after a flush.
REQ-002 ms_riscv32_mp_clk_in  input  1  clock SHALL be used, rising edge active.
REQ-003 ms_riscv32_mp_rst_in  input  1  reset SHALL be asynchronous and active-high.
REQ-004 pc_in  input  32  SHALL carry the current PC from the PC register.
REQ-005 flush_in  input  1  SHALL be a redirect (branch/trap) request that discards in-flight and held fetches.
REQ-006 stall_in  input  1  SHALL be high while downstream cannot accept the held instruction.
REQ-007 imem_req_out  output  1  SHALL be the instruction-memory request valid.
REQ-008 imem_addr_out  output  32  SHALL be the request address.
REQ-009 imem_gnt_in  input  1  SHALL be the memory's acceptance of the request.
REQ-010 imem_rvalid_in  input  1  SHALL qualify imem_rdata_in.
REQ-011 imem_rdata_in  input  32  SHALL be the returned instruction word.
REQ-012 instr_out  output  32  SHALL be the fetched instruction to decode.
REQ-013 instr_pc_out  output  32  SHALL be the PC of instr_out.
REQ-014 instr_valid_out  output  1  SHALL qualify instr_out/instr_pc_out.
REQ-015 pc_advance_out  output  1  SHALL tell the PC mux to select pc_in+4 for one cycle.
REQ-016 misaligned_out  output  1  SHALL flag pc_in[1:0] != 0 while a request is pending.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, VALID, plus a 1-bit drop flag and a 32-bit captured-PC register pc_q.
REQ-018 IDLE SHALL go to REQ unconditionally on the next edge.
REQ-019 In REQ: imem_req_out = (pc_in[1:0]==0), imem_addr_out = pc_in (combinational), misaligned_out = (pc_in[1:0]!=0).
REQ-020 In REQ with misaligned pc_in, no request SHALL issue; FSM SHALL stay in REQ until flush_in.
REQ-021 In REQ on imem_gnt_in && imem_req_out: pc_q <= pc_in, go WAIT; drop <= flush_in.
REQ-022 In REQ with flush_in and no grant: stay REQ (re-request from redirected pc_in next cycle).
REQ-023 In WAIT with flush_in and no imem_rvalid_in: drop <= 1, stay WAIT.
REQ-024 In WAIT on imem_rvalid_in with drop==0 and flush_in==0: instr_out <= imem_rdata_in, instr_pc_out <= pc_q, instr_valid_out <= 1, pc_advance_out <= 1 (one cycle), go VALID.
REQ-025 In WAIT on imem_rvalid_in with drop==1 or flush_in==1: response discarded, drop <= 0, no pc_advance_out, go REQ.
REQ-026 imem_rvalid_in outside WAIT SHALL be ignored.
REQ-027 In VALID, stall_in==1 and flush_in==0: instr_out, instr_pc_out, instr_valid_out held unchanged.
REQ-028 In VALID, stall_in==0: instr_valid_out <= 0, go REQ (one instruction per 3 cycles minimum with 0-wait memory).
REQ-029 In VALID, flush_in==1 (priority over stall_in): instr_valid_out <= 0, instr_out <= RESET_INSTR, go REQ.
REQ-030 pc_advance_out SHALL be a registered single-cycle pulse, so the PC register updates before the next REQ samples pc_in.
REQ-031 imem_req_out and misaligned_out SHALL be 0 outside REQ.

Reset
REQ-032 On reset: state IDLE, drop 0, pc_q 0, instr_out RESET_INSTR, instr_pc_out 0, instr_valid_out 0, pc_advance_out 0; imem_req_out 0, misaligned_out 0.
REQ-033 Reset mid-WAIT SHALL abandon the transaction; a late imem_rvalid_in after reset release SHALL be ignored (state not WAIT).

Verification
REQ-034 pc_in=0x100, gnt same cycle, rvalid next cycle with 0x00500093 -> instr_out=0x00500093, instr_pc_out=0x100, valid=1, one pc_advance_out pulse.
REQ-035 Held valid, stall_in=1 for 4 cycles -> outputs stable, no imem_req_out; stall_in=0 -> valid drops, REQ on pc_in=0x104.
REQ-036 flush_in in WAIT, rvalid 2 cycles later with 0xDEADBEEF -> discarded, valid stays 0, no pc_advance_out, next request at redirected pc_in=0x200.
REQ-037 flush_in coincident with imem_rvalid_in -> response dropped, FSM to REQ.
REQ-038 pc_in=0x102 in REQ -> misaligned_out=1, imem_req_out=0; flush_in with pc_in=0x300 -> request 0x300.
REQ-039 Assert reset during WAIT, release, drive stray rvalid -> ignored; outputs at REQ-032 values until first fetch.
